alu_result_checker: RTL and testbench
=====================================

// Module: alu_result_checker
// PURPOSE
//  Self-checking monitor for the TOP processor's ALUResult/ALUFlags stream. It compares each
//  qualified sample, in order, against a programmable table of expected result/flag pairs.
//  It reports pass/fail/timeout plus match/error statistics.
//  Generalises the single hard-coded end-of-program check into a parametrised, multi-checkpoint,
//  synthesizable checker. The same block serves benches and on-board debug.
// PARAMETERS
//  DATA_W        32    width of ALU result
//  FLAG_W        4     width of ALU flags (NZCV)
//  DEPTH         8     number of expected-value entries (power of 2, >=2)
//  TIMEOUT_CYC   1024  max idle cycles between samples in RUN before timeout (>=1)
//  STOP_ON_FAIL  1     1: finish at first mismatch; 0: check all entries, accumulate errors
// PORTS
//  clk            in   1                 system clock, rising edge
//  reset          in   1                 asynchronous, active-low reset
//  start          in   1                 pulse: begin a check run (accepted only in IDLE/DONE)
//  num_exp        in   $clog2(DEPTH)+1   entries to check this run, 0..DEPTH; sampled at start
//  exp_wr_en      in   1                 write expected entry (ignored while busy)
//  exp_wr_addr    in   $clog2(DEPTH)     entry index
//  exp_wr_result  in   DATA_W            expected ALUResult
//  exp_wr_flags   in   FLAG_W            expected ALUFlags
//  exp_wr_fmask   in   FLAG_W            flag compare mask, 1 = bit compared
//  sample_valid   in   1                 ALU sample qualifier (one sample per high cycle)
//  alu_result     in   DATA_W            observed ALUResult
//  alu_flags      in   FLAG_W            observed ALUFlags
//  busy           out  1                 high in RUN
//  done           out  1                 one-cycle pulse on entering DONE
//  pass           out  1                 level in DONE: all checked entries matched, no timeout
//  fail           out  1                 level in DONE: >=1 mismatch or timeout
//  timed_out      out  1                 level in DONE: run ended by timeout
//  first_bad_idx  out  $clog2(DEPTH)     index of first mismatching entry
//  first_bad_val  out  DATA_W            alu_result captured at first mismatch
//  match_count    out  $clog2(DEPTH)+1   matching samples this run
//  error_count    out  $clog2(DEPTH)+1   mismatching samples this run
// BEHAVIOUR
//  - Reset: FSM=IDLE; all outputs 0; index, counters and timeout counter 0. Table contents not reset.
//  - FSM IDLE -> RUN on start; DONE -> RUN on start, which clears counters, verdicts and first_bad_*.
//  - RUN -> DONE when any of these holds:
//      idx reaches num_exp;
//      mismatch with STOP_ON_FAIL=1;
//      idle counter reaches TIMEOUT_CYC.
//  - DONE holds its verdicts until the next start or reset.
//  - Compare, registered, 1-cycle latency. A sample matches when both hold:
//      alu_result == exp_result;
//      (alu_flags ^ exp_flags) & fmask == 0.
//    On a match, match_count increments. On a mismatch, error_count increments; first_bad_idx/val
//    latch only on the first mismatch. idx then increments.
//  - done pulses the cycle after the last compare registers. pass/fail/timed_out are valid in that
//    same cycle.
//  - Timeout counter: clears on start and on each sample_valid, and increments otherwise in RUN.
//    On reaching TIMEOUT_CYC: timed_out=1, fail=1. A sample in that same cycle is still compared.
//  - num_exp==0 at start: RUN lasts one cycle, then DONE with pass=1 and counts 0.
//  - num_exp>DEPTH is clamped to DEPTH.
//  - sample_valid outside RUN is ignored; samples beyond num_exp are ignored.
//  - exp_wr_en while busy is dropped. A same-cycle start + exp_wr_en in IDLE: the write lands first.
//  - start while busy is ignored. Reset mid-run returns to IDLE immediately, with no done pulse.
//  - pass and fail are never high together; both are 0 outside DONE.
// STRUCTURE
//  - Package checker_pkg:
//      typedef enum {IDLE,RUN,DONE} chk_state_t;
//      struct exp_entry_t {result, flags, fmask};
//      verdict encodings.
//  - Sub-module checker_table: DEPTH x exp_entry_t register file, 1 write port, 1 async read port.
//  - Top holds the FSM, compare stage, counters and timeout counter.
// TESTING
//  1. Load 3 entries {0x64/0000, 0x60/0100, 7/0000}, fmask 1111, num_exp=3; feed matching samples
//     -> done with pass=1, match_count=3, error_count=0.
//  2. STOP_ON_FAIL=1; entry1 expects 0x64, feed 0x60 -> done one cycle after that sample;
//     fail=1, first_bad_idx=1, first_bad_val=0x60.
//  3. STOP_ON_FAIL=0, same stimulus as 2 -> runs to 3 samples; error_count=1, match_count=2, fail=1.
//  4. fmask=0001, expected flags 0001, observed 1111 -> match. Observed 1110 -> mismatch.
//  5. TIMEOUT_CYC=16; start, then no sample_valid -> done after 16 cycles; timed_out=1, fail=1,
//     pass=0.
//  6. Assert reset mid-RUN, then start with num_exp=0 -> IDLE with outputs 0; then done, pass=1
//     within 2 cycles.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared types for the ALU result checker: FSM states, expected-entry layout, verdicts.
package checker_pkg;

  localparam int unsigned ENTRY_DATA_W = 32;
  localparam int unsigned ENTRY_FLAG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } chk_state_t;

  typedef struct packed {
    logic [ENTRY_DATA_W-1:0] result;
    logic [ENTRY_FLAG_W-1:0] flags;
    logic [ENTRY_FLAG_W-1:0] fmask;
  } exp_entry_t;

  localparam int unsigned ENTRY_W = $bits(exp_entry_t);

  typedef enum logic [1:0] {
    VERDICT_NONE,
    VERDICT_PASS,
    VERDICT_FAIL,
    VERDICT_TIMEOUT
  } verdict_t;

endpackage

// File: rtl/checker_table.sv
// Expected-value register file: one synchronous write port, one asynchronous read port.
module checker_table
  import checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ENTRY_W-1:0]       rd_data
);

  // Contents are intentionally left unreset; software reloads them before each run.
  exp_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= exp_entry_t'(wr_data);
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_result_checker.sv
// Compares qualified ALU result/flag samples in order against a programmed expected table.
module alu_result_checker
  import checker_pkg::*;
#(
  parameter int unsigned DATA_W       = ENTRY_DATA_W,
  parameter int unsigned FLAG_W       = ENTRY_FLAG_W,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned TIMEOUT_CYC  = 1024,
  parameter int unsigned STOP_ON_FAIL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_exp,
  input  logic                     exp_wr_en,
  input  logic [$clog2(DEPTH)-1:0] exp_wr_addr,
  input  logic [DATA_W-1:0]        exp_wr_result,
  input  logic [FLAG_W-1:0]        exp_wr_flags,
  input  logic [FLAG_W-1:0]        exp_wr_fmask,
  input  logic                     sample_valid,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [FLAG_W-1:0]        alu_flags,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timed_out,
  output logic [$clog2(DEPTH)-1:0] first_bad_idx,
  output logic [DATA_W-1:0]        first_bad_val,
  output logic [$clog2(DEPTH):0]   match_count,
  output logic [$clog2(DEPTH):0]   error_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  chk_state_t        state, state_next;
  verdict_t          verdict, verdict_next;
  logic [CW-1:0]     idx, n_exp, n_clamped;
  logic [TW-1:0]     idle_cnt;
  logic              done_q;
  logic [ENTRY_W-1:0] wr_data, rd_data;
  exp_entry_t        wr_entry, cur;
  logic              start_ok, take, is_match, mismatch, last, timeout_hit, finish;

  always_comb begin
    wr_entry        = '0;
    wr_entry.result = exp_wr_result;
    wr_entry.flags  = exp_wr_flags;
    wr_entry.fmask  = exp_wr_fmask;
  end
  assign wr_data = wr_entry;

  checker_table #(.DEPTH(DEPTH)) u_table (
    .clk     (clk),
    .wr_en   (exp_wr_en && (state != RUN)),
    .wr_addr (exp_wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx[AW-1:0]),
    .rd_data (rd_data)
  );

  assign cur       = exp_entry_t'(rd_data);
  assign n_clamped = (num_exp > CW'(DEPTH)) ? CW'(DEPTH) : num_exp;
  assign start_ok  = start && (state != RUN);
  assign take      = (state == RUN) && sample_valid && (idx < n_exp);
  assign is_match  = (alu_result == cur.result) &&
                     (((alu_flags ^ cur.flags) & cur.fmask) == '0);
  assign mismatch  = take && !is_match;
  assign last      = take && ((idx + CW'(1)) == n_exp);
  // A sample clears the idle count, so a timeout can only fire on a sample-free cycle.
  assign timeout_hit = (state == RUN) && !sample_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign finish      = (state == RUN) &&
                       ((idx == n_exp) || last || (mismatch && (STOP_ON_FAIL != 0)) || timeout_hit);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    verdict_next = VERDICT_PASS;
    if (timeout_hit)                        verdict_next = VERDICT_TIMEOUT;
    else if ((error_count != '0) || mismatch) verdict_next = VERDICT_FAIL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      verdict       <= VERDICT_NONE;
      idx           <= '0;
      n_exp         <= '0;
      idle_cnt      <= '0;
      done_q        <= 1'b0;
      match_count   <= '0;
      error_count   <= '0;
      first_bad_idx <= '0;
      first_bad_val <= '0;
    end else begin
      state  <= state_next;
      done_q <= finish;
      if (start_ok) begin
        verdict       <= VERDICT_NONE;
        idx           <= '0;
        n_exp         <= n_clamped;
        idle_cnt      <= '0;
        match_count   <= '0;
        error_count   <= '0;
        first_bad_idx <= '0;
        first_bad_val <= '0;
      end else if (state == RUN) begin
        idle_cnt <= sample_valid ? '0 : idle_cnt + TW'(1);
        if (take) begin
          idx <= idx + CW'(1);
          if (is_match) begin
            match_count <= match_count + CW'(1);
          end else begin
            error_count <= error_count + CW'(1);
            if (error_count == '0) begin
              first_bad_idx <= idx[AW-1:0];
              first_bad_val <= alu_result;
            end
          end
        end
        if (finish) verdict <= verdict_next;
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = done_q;
  assign pass      = (state == DONE) && (verdict == VERDICT_PASS);
  assign fail      = (state == DONE) && ((verdict == VERDICT_FAIL) || (verdict == VERDICT_TIMEOUT));
  assign timed_out = (state == DONE) && (verdict == VERDICT_TIMEOUT);

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench: one stop-on-fail and one accumulate-errors checker driven with shared stimulus.
module tb_alu_result_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  num_exp = '0;
  logic        exp_wr_en = 1'b0;
  logic [2:0]  exp_wr_addr = '0;
  logic [31:0] exp_wr_result = '0;
  logic [3:0]  exp_wr_flags = '0;
  logic [3:0]  exp_wr_fmask = '0;
  logic        sample_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;

  logic        s_busy, s_done, s_pass, s_fail, s_to;
  logic [2:0]  s_bidx;
  logic [31:0] s_bval;
  logic [3:0]  s_mc, s_ec;
  logic        a_busy, a_done, a_pass, a_fail, a_to;
  logic [2:0]  a_bidx;
  logic [31:0] a_bval;
  logic [3:0]  a_mc, a_ec;

  int total = 0;
  int bad = 0;
  int cyc;

  always #5 clk = ~clk;

  alu_result_checker #(.DATA_W(32), .FLAG_W(4), .DEPTH(8), .TIMEOUT_CYC(16), .STOP_ON_FAIL(1)) u_stop (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_result(exp_wr_result),
    .exp_wr_flags(exp_wr_flags), .exp_wr_fmask(exp_wr_fmask),
    .sample_valid(sample_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail(s_fail), .timed_out(s_to),
    .first_bad_idx(s_bidx), .first_bad_val(s_bval), .match_count(s_mc), .error_count(s_ec)
  );

  alu_result_checker #(.DATA_W(32), .FLAG_W(4), .DEPTH(8), .TIMEOUT_CYC(16), .STOP_ON_FAIL(0)) u_acc (
    .clk(clk), .reset(reset), .start(start), .num_exp(num_exp),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_result(exp_wr_result),
    .exp_wr_flags(exp_wr_flags), .exp_wr_fmask(exp_wr_fmask),
    .sample_valid(sample_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail), .timed_out(a_to),
    .first_bad_idx(a_bidx), .first_bad_val(a_bval), .match_count(a_mc), .error_count(a_ec)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] a, input logic [31:0] r, input logic [3:0] f, input logic [3:0] m);
    exp_wr_en = 1'b1; exp_wr_addr = a; exp_wr_result = r; exp_wr_flags = f; exp_wr_fmask = m;
    tick();
    exp_wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] n);
    num_exp = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sample(input logic [31:0] r, input logic [3:0] f);
    sample_valid = 1'b1; alu_result = r; alu_flags = f;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_pass_fail", {s_pass, s_fail, s_to}, 0);
    check("rst_counts", {s_mc, s_ec}, 0);
    reset = 1'b1;
    tick();

    // 1: three matching samples; a write attempted while busy must be dropped
    write_entry(3'd0, 32'h64, 4'b0000, 4'b1111);
    write_entry(3'd1, 32'h60, 4'b0100, 4'b1111);
    write_entry(3'd2, 32'h07, 4'b0000, 4'b1111);
    do_start(4'd3);
    check("t1_busy", s_busy, 1);
    exp_wr_en = 1'b1; exp_wr_addr = 3'd2; exp_wr_result = 32'hdead; exp_wr_flags = 4'b1111;
    sample(32'h64, 4'b0000);
    exp_wr_en = 1'b0;
    sample(32'h60, 4'b0100);
    check("t1_mid_done", s_done, 0);
    check("t1_mid_match", s_mc, 2);
    sample(32'h07, 4'b0000);
    check("t1_done", s_done, 1);
    check("t1_pass", s_pass, 1);
    check("t1_fail", s_fail, 0);
    check("t1_match", s_mc, 3);
    check("t1_err", s_ec, 0);
    check("t1_busy_end", s_busy, 0);
    tick();
    check("t1_done_pulse", s_done, 0);
    check("t1_pass_hold", s_pass, 1);

    // 2/3: entry1 expects 0x64, observed 0x60
    write_entry(3'd1, 32'h64, 4'b0100, 4'b1111);
    do_start(4'd3);
    check("t2_cleared", {s_pass, s_mc}, 0);
    sample(32'h64, 4'b0000);
    sample(32'h60, 4'b0100);
    check("t2_done", s_done, 1);
    check("t2_fail", {s_fail, s_pass}, 2'b10);
    check("t2_bad_idx", s_bidx, 1);
    check("t2_bad_val", s_bval, 32'h60);
    check("t2_err", s_ec, 1);
    check("t3_still_busy", a_busy, 1);
    check("t3_mid_err", a_ec, 1);
    sample(32'h07, 4'b0000);
    check("t3_done", a_done, 1);
    check("t3_match", a_mc, 2);
    check("t3_err", a_ec, 1);
    check("t3_fail", {a_fail, a_pass}, 2'b10);
    check("t3_bad_idx", a_bidx, 1);
    check("t2_ignored_after_done", s_mc, 1);

    // 4: flag mask compares only bit 0
    write_entry(3'd0, 32'h5, 4'b0001, 4'b0001);
    write_entry(3'd1, 32'h5, 4'b0001, 4'b0001);
    do_start(4'd2);
    sample(32'h5, 4'b1111);
    check("t4_masked_match", a_mc, 1);
    check("t4_no_err", a_ec, 0);
    sample(32'h5, 4'b1110);
    check("t4_done", a_done, 1);
    check("t4_err", a_ec, 1);
    check("t4_bad_idx", a_bidx, 1);
    check("t4_fail", a_fail, 1);

    // 5: timeout after 16 idle cycles
    do_start(4'd1);
    cyc = 0;
    for (int i = 0; i < 40 && !s_done; i++) begin
      tick();
      cyc++;
    end
    check("t5_cycles", cyc, 16);
    check("t5_flags", {s_to, s_fail, s_pass}, 3'b110);
    check("t5_acc_flags", {a_done, a_to, a_fail}, 3'b111);

    // 6: reset mid-run, then an empty run
    do_start(4'd3);
    tick();
    check("t6_busy", s_busy, 1);
    reset = 1'b0;
    #2;
    check("t6_rst_out", {s_busy, s_done, s_pass, s_fail, s_to}, 0);
    check("t6_rst_counts", {s_mc, s_ec, s_bidx}, 0);
    reset = 1'b1;
    tick();
    check("t6_no_done", s_done, 0);
    do_start(4'd0);
    check("t6_run", {s_busy, s_done}, 2'b10);
    tick();
    check("t6_done", {s_done, s_pass, s_fail}, 3'b110);
    check("t6_counts", {s_mc, s_ec}, 0);
    check("t6_excl", s_pass & s_fail, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
